wide_adder_seq: RTL and testbench

Multi-precision add sequencer that computes a WORDS×WIDTH-bit sum by time-multiplexing one WIDTH-bit `adder_32` datapath, one word per cycle, least-significant word first, with the carry chained through a register. It sits between a requester and consumer using valid/ready handshakes and is the control layer for the existing 32-bit adder.

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_32.sv | 17 +
 rtl/wide_adder_seq.sv | 133 +++++++++++++
 tb/tb_wide_adder_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_WORDS     = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_32.sv
// Combinational word adder: sum and carry out of a + b + carry_in.
module adder_32
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Extend every operand by one bit so the carry lands in the top bit.
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/wide_adder_seq.sv
// Multi-precision add sequencer: adds WORDS words of WIDTH bits one word per
// cycle, least-significant first, through a single shared adder_32 with the
// carry chained through a register.
module wide_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WORDS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [WIDTH*WORDS-1:0] a_i,
    input  logic [WIDTH*WORDS-1:0] b_i,
    input  logic                   carry_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [WIDTH*WORDS-1:0] sum_o,
    output logic                   carry_o,
    output logic                   busy_o
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS + 1);
    localparam int LSB_W = $clog2(TOTAL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t state;
    state_t next_state;

    logic [TOTAL-1:0] a_q;
    logic [TOTAL-1:0] b_q;
    logic [TOTAL-1:0] sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [LSB_W-1:0] word_lsb;
    logic             last_word;
    logic             accept;

    logic [WIDTH-1:0] word_sum;
    logic             word_carry;

    // Bit offset of the word currently being processed.
    assign word_lsb  = LSB_W'(idx) * LSB_W'(WIDTH);
    assign last_word = (idx == LAST_IDX);

    adder_32 #(.WIDTH(WIDTH)) u_adder (
        .a         (a_q[word_lsb +: WIDTH]),
        .b         (b_q[word_lsb +: WIDTH]),
        .carry_in  (carry_q),
        .sum       (word_sum),
        .carry_out (word_carry)
    );

    // State register; reset wins over any transition.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode from the state register.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        next_state  = state;
        accept      = 1'b0;
        req_ready_o = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Ready is held off while reset is asserted.
                req_ready_o = !rst_i;
                if (req_valid_i && !rst_i) begin
                    accept     = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (last_word) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture and word-serial accumulation into the result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the wide operand/result registers are cleared on reset
            // because sum_o and carry_o must read zero afterwards.
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            sum_q   <= '0;
            carry_q <= carry_i;
            idx     <= '0;
        end else if (state == S_RUN) begin
            sum_q[word_lsb +: WIDTH] <= word_sum;
            carry_q                  <= word_carry;
            // Index saturates on the last word rather than wrapping.
            if (!last_word) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_wide_adder_seq.sv
// Self-checking bench for wide_adder_seq: a transaction-level model predicts
// handshakes and results each cycle, backed by hand-computed directed cases.
module tb_wide_adder_seq;

    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int TOTAL = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [TOTAL-1:0] a_i = '0;
    logic [TOTAL-1:0] b_i = '0;
    logic             carry_i = 1'b0;
    logic             res_valid_o;
    logic             res_ready_i = 1'b1;
    logic [TOTAL-1:0] sum_o;
    logic             carry_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: one outstanding transaction with its expected result.
    int               cyc = 0;
    bit               pending = 1'b0;
    int               c0 = 0;
    logic [TOTAL:0]   full;
    logic [TOTAL-1:0] exp_sum = '0;
    logic             exp_carry = 1'b0;
    int               n_accepts = 0;
    int               n_results = 0;
    int               acc_q[$];

    wide_adder_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .carry_i     (carry_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .sum_o       (sum_o),
        .carry_o     (carry_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [TOTAL:0] act, input logic [TOTAL:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: accept when idle, result due WORDS cycles later,
    // retired on a consumer handshake; reset discards everything.
    always @(posedge clk) begin
        if (rst_i) begin
            pending = 1'b0;
        end else if (!pending && req_valid_i) begin
            full      = {1'b0, a_i} + {1'b0, b_i} + {{TOTAL{1'b0}}, carry_i};
            exp_sum   = full[TOTAL-1:0];
            exp_carry = full[TOTAL];
            pending   = 1'b1;
            c0        = cyc + 1;
            n_accepts++;
            acc_q.push_back(c0);
        end else if (pending && (cyc - c0 >= WORDS) && res_ready_i) begin
            pending = 1'b0;
            n_results++;
        end
        cyc++;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("res_valid", res_valid_o, pending && (cyc - c0 >= WORDS));
            check("req_ready", req_ready_o, !pending && !rst_i);
            check("busy", busy_o, pending);
            if (pending && (cyc - c0 >= WORDS)) begin
                check("sum", sum_o, exp_sum);
                check("carry", carry_o, exp_carry);
            end
        end
    end

    task automatic do_req(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b, input logic c);
        int start;
        start = n_accepts;
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        a_i         = a;
        b_i         = b;
        carry_i     = c;
        for (int i = 0; i < 50 && n_accepts == start; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        check("accept_seen", n_accepts - start, 1);
    endtask

    task automatic wait_result();
        @(negedge clk);
        for (int i = 0; i < 50 && !res_valid_o; i++) begin
            @(negedge clk);
        end
        check("result_seen", res_valid_o, 1'b1);
    endtask

    logic [TOTAL-1:0] sa[10];
    logic [TOTAL-1:0] sb[10];
    logic             sc[10];

    initial begin
        int start;
        int base;
        int loaded;
        int t;
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", res_valid_o, 1'b0);
        check("rst_sum", sum_o, '0);
        check("rst_carry", carry_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", req_ready_o, 1'b0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_release", req_ready_o, 1'b1);

        // All ones + 1: ripples through every word
        do_req({TOTAL{1'b1}}, 128'd1, 1'b0);
        wait_result();
        check("t1_sum", sum_o, '0);
        check("t1_carry", carry_o, 1'b1);
        check("t1_latency", cyc - c0, 4);

        // Carry across the word-0/word-1 boundary
        do_req(128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0);
        wait_result();
        check("t2_sum", sum_o, 128'h00000000_00000000_00000001_00000000);
        check("t2_carry", carry_o, 1'b0);

        // Carry-in alone, then top-bit overflow
        do_req('0, '0, 1'b1);
        wait_result();
        check("t3a_sum", sum_o, 128'd1);
        check("t3a_carry", carry_o, 1'b0);
        do_req(128'h80000000_00000000_00000000_00000000, 128'h80000000_00000000_00000000_00000000, 1'b0);
        wait_result();
        check("t3b_sum", sum_o, '0);
        check("t3b_carry", carry_o, 1'b1);

        // Backpressure while a new request waits
        @(posedge clk);
        #1 res_ready_i = 1'b0;
        do_req(128'd5, 128'd7, 1'b0);
        wait_result();
        check("bp_sum0", sum_o, 128'd12);
        @(posedge clk);
        #1;
        start       = n_accepts;
        req_valid_i = 1'b1;
        a_i         = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF;
        b_i         = 128'd1;
        carry_i     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", res_valid_o, 1'b1);
            check("bp_sum", sum_o, 128'd12);
            check("bp_carry", carry_o, 1'b0);
            check("bp_ready", req_ready_o, 1'b0);
        end
        @(posedge clk);
        #1;
        res_ready_i = 1'b1;
        t           = cyc;
        for (int i = 0; i < 10 && n_accepts == start; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        check("bp_accepted", n_accepts - start, 1);
        check("bp_accept_delay", c0 - t, 2);
        wait_result();
        check("bp_sum1", sum_o, 128'h00000000_00000001_00000000_00000001);
        check("bp_carry1", carry_o, 1'b0);

        // Reset after two RUN cycles aborts the operation
        do_req(128'h11111111_22222222_33333333_44444444, 128'h01010101_01010101_01010101_01010101, 1'b0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", res_valid_o, 1'b0);
        check("abort_sum", sum_o, '0);
        check("abort_carry", carry_o, 1'b0);
        check("abort_ready", req_ready_o, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid_o) seen++;
        end
        check("abort_no_result", seen, 0);

        // Streaming with valid and ready held high
        for (int i = 0; i < 10; i++) begin
            sa[i] = {$urandom, $urandom, $urandom, $urandom};
            sb[i] = {$urandom, $urandom, $urandom, $urandom};
            sc[i] = 1'($urandom_range(0, 1));
        end
        sa[0] = {TOTAL{1'b1}};
        start  = n_accepts;
        base   = acc_q.size();
        loaded = 0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        a_i         = sa[0];
        b_i         = sb[0];
        carry_i     = sc[0];
        for (int g = 0; g < 200 && (n_accepts - start) < 10; g++) begin
            @(posedge clk);
            #1;
            if (n_accepts - start > loaded) begin
                loaded++;
                if (loaded < 10) begin
                    a_i     = sa[loaded];
                    b_i     = sb[loaded];
                    carry_i = sc[loaded];
                end else begin
                    req_valid_i = 1'b0;
                end
            end
        end
        req_valid_i = 1'b0;
        check("stream_accepts", n_accepts - start, 10);
        for (int i = 1; i < 10; i++) begin
            if (base + i < acc_q.size()) begin
                check("stream_spacing", acc_q[base + i] - acc_q[base + i - 1], WORDS + 2);
            end
        end
        for (int g = 0; g < 50 && pending; g++) begin
            @(posedge clk);
            #1;
        end
        check("stream_drained", pending, 1'b0);
        check("result_count", n_results, 16);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failed=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
